// File: rtl/wb_commit_unit.sv
// Write-back commit stage: drives the single register-file write port from the
// registered MEM/WB fields and sequences the extra base-update write over two cycles.
module wb_commit_unit #(
  parameter int WORD_LEN          = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int CNT_LEN           = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN,
  input  logic                         MEM_R_EN,
  input  logic [WORD_LEN-1:0]          ALURes,
  input  logic [WORD_LEN-1:0]          memReadVal,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic                         add_base,
  input  logic [WORD_LEN-1:0]          val1,
  input  logic [REG_FILE_ADDR_LEN-1:0] base_dest,
  output logic                         wb_en_out,
  output logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
  output logic [WORD_LEN-1:0]          wb_value,
  output logic                         stall,
  output logic [CNT_LEN-1:0]           wb_count
);

  typedef enum logic {
    IDLE = 1'b0,
    BASE = 1'b1
  } state_t;

  state_t                       state, state_nxt;
  logic [WORD_LEN-1:0]          hb_val, hb_val_nxt;
  logic [REG_FILE_ADDR_LEN-1:0] hb_dest, hb_dest_nxt;
  logic                         en_raw;
  logic                         en_nxt;
  logic [REG_FILE_ADDR_LEN-1:0] dest_nxt;
  logic [WORD_LEN-1:0]          value_nxt;
  logic                         stall_nxt;
  logic [WORD_LEN-1:0]          pval;

  assign pval = MEM_R_EN ? memReadVal : ALURes;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt   = state;
    en_raw      = 1'b0;
    dest_nxt    = wb_dest;
    value_nxt   = wb_value;
    stall_nxt   = 1'b0;
    hb_val_nxt  = hb_val;
    hb_dest_nxt = hb_dest;

    unique case (state)
      IDLE: begin
        if (WB_EN) begin
          en_raw    = 1'b1;
          dest_nxt  = dest;
          value_nxt = pval;
          if (add_base) begin
            hb_val_nxt  = val1;
            hb_dest_nxt = base_dest;
            stall_nxt   = 1'b1;
            state_nxt   = BASE;
          end
        end else if (add_base) begin
          // Base-only update fits in one slot, so no stall is needed.
          en_raw    = 1'b1;
          dest_nxt  = base_dest;
          value_nxt = val1;
        end
      end
      BASE: begin
        // Upstream holds MEM/WB steady while stalled, so the inputs are ignored here.
        en_raw    = 1'b1;
        dest_nxt  = hb_dest;
        value_nxt = hb_val;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register 0 is hard-wired; a write aimed at it is dropped but the sequence still advances.
  assign en_nxt = en_raw && (dest_nxt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hb_val    <= '0;
      hb_dest   <= '0;
      wb_en_out <= 1'b0;
      wb_dest   <= '0;
      wb_value  <= '0;
      stall     <= 1'b0;
      wb_count  <= '0;
    end else begin
      state     <= state_nxt;
      hb_val    <= hb_val_nxt;
      hb_dest   <= hb_dest_nxt;
      wb_en_out <= en_nxt;
      wb_dest   <= dest_nxt;
      wb_value  <= value_nxt;
      stall     <= stall_nxt;
      if (en_nxt) wb_count <= wb_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: each task drives one scenario and compares the
// packed output tuple {wb_en_out, wb_dest, wb_value, stall, wb_count} inline.
module tb_wb_commit_unit;

  localparam int WL = 32;
  localparam int AL = 5;
  localparam int CL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          WB_EN, MEM_R_EN, add_base;
  logic [WL-1:0] ALURes, memReadVal, val1;
  logic [AL-1:0] dest, base_dest;
  logic          wb_en_out, stall;
  logic [AL-1:0] wb_dest;
  logic [WL-1:0] wb_value;
  logic [CL-1:0] wb_count;

  logic [CL-1:0]           exp_cnt;
  logic [1+AL+WL+1+CL-1:0] obs;
  int checks = 0;
  int errors = 0;

  assign obs = {wb_en_out, wb_dest, wb_value, stall, wb_count};

  wb_commit_unit #(.WORD_LEN(WL), .REG_FILE_ADDR_LEN(AL), .CNT_LEN(CL)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALURes(ALURes),
    .memReadVal(memReadVal), .dest(dest), .add_base(add_base), .val1(val1),
    .base_dest(base_dest), .wb_en_out(wb_en_out), .wb_dest(wb_dest),
    .wb_value(wb_value), .stall(stall), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WB_EN = 0; MEM_R_EN = 0; add_base = 0;
    ALURes = '0; memReadVal = '0; val1 = '0; dest = '0; base_dest = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    exp_cnt = '0;
    #2;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", obs);
    end
  endtask

  task automatic test_alu_load();
    WB_EN = 1; MEM_R_EN = 0; ALURes = 32'h1234; dest = 3;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd3, 32'h1234, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL alu_write: got %h expected %h", obs, {1'b1, 5'd3, 32'h1234, 1'b0, exp_cnt});
    end
    MEM_R_EN = 1; memReadVal = 32'hCAFE; dest = 4;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd4, 32'hCAFE, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL load_write: got %h expected %h", obs, {1'b1, 5'd4, 32'hCAFE, 1'b0, exp_cnt});
    end
    idle_inputs();
    tick();
    checks++;
    if (obs !== {1'b0, 5'd4, 32'hCAFE, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL idle_hold: got %h expected %h", obs, {1'b0, 5'd4, 32'hCAFE, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_load_base();
    WB_EN = 1; MEM_R_EN = 1; memReadVal = 32'hAA; dest = 5;
    add_base = 1; val1 = 32'h104; base_dest = 6;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd5, 32'hAA, 1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL load_base_primary: got %h expected %h", obs, {1'b1, 5'd5, 32'hAA, 1'b1, exp_cnt});
    end
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd6, 32'h104, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL load_base_second: got %h expected %h", obs, {1'b1, 5'd6, 32'h104, 1'b0, exp_cnt});
    end
    idle_inputs();
    tick();
    checks++;
    if ({wb_en_out, stall, wb_count} !== {1'b0, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL load_base_done: got %h expected %h", {wb_en_out, stall, wb_count}, {1'b0, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_same_index();
    WB_EN = 1; MEM_R_EN = 0; ALURes = 32'h11; dest = 7;
    add_base = 1; val1 = 32'h22; base_dest = 7;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd7, 32'h11, 1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL same_index_first: got %h expected %h", obs, {1'b1, 5'd7, 32'h11, 1'b1, exp_cnt});
    end
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd7, 32'h22, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL same_index_base: got %h expected %h", obs, {1'b1, 5'd7, 32'h22, 1'b0, exp_cnt});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] stall_seq;
    WB_EN = 1; MEM_R_EN = 0; ALURes = 32'h1; dest = 10;
    add_base = 1; val1 = 32'h2; base_dest = 11;
    tick(); exp_cnt++; stall_seq[3] = stall;
    tick(); exp_cnt++; stall_seq[2] = stall;
    checks++;
    if (obs !== {1'b1, 5'd11, 32'h2, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL b2b_first_base: got %h expected %h", obs, {1'b1, 5'd11, 32'h2, 1'b0, exp_cnt});
    end
    ALURes = 32'h3; dest = 12; val1 = 32'h4; base_dest = 13;
    tick(); exp_cnt++; stall_seq[1] = stall;
    checks++;
    if (obs !== {1'b1, 5'd12, 32'h3, 1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL b2b_second_primary: got %h expected %h", obs, {1'b1, 5'd12, 32'h3, 1'b1, exp_cnt});
    end
    tick(); exp_cnt++; stall_seq[0] = stall;
    checks++;
    if (obs !== {1'b1, 5'd13, 32'h4, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL b2b_second_base: got %h expected %h", obs, {1'b1, 5'd13, 32'h4, 1'b0, exp_cnt});
    end
    checks++;
    if (stall_seq !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_stall_pattern: got %b expected 1010", stall_seq);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_zero_and_base_only();
    WB_EN = 1; MEM_R_EN = 0; ALURes = 32'h77; dest = 0;
    tick();
    checks++;
    if ({wb_en_out, stall, wb_count} !== {1'b0, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL zero_reg: got %h expected %h", {wb_en_out, stall, wb_count}, {1'b0, 1'b0, exp_cnt});
    end
    idle_inputs();
    add_base = 1; base_dest = 9; val1 = 32'h40;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd9, 32'h40, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL base_only: got %h expected %h", obs, {1'b1, 5'd9, 32'h40, 1'b0, exp_cnt});
    end
    idle_inputs();
    tick();
    checks++;
    if ({wb_en_out, stall, wb_count} !== {1'b0, 1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL base_only_single: got %h expected %h", {wb_en_out, stall, wb_count}, {1'b0, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_reset_mid();
    WB_EN = 1; MEM_R_EN = 0; ALURes = 32'h99; dest = 14;
    add_base = 1; val1 = 32'h55; base_dest = 15;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd14, 32'h99, 1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL mid_enter_base: got %h expected %h", obs, {1'b1, 5'd14, 32'h99, 1'b1, exp_cnt});
    end
    #2 rst = 0;
    exp_cnt = '0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected 0", obs);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_no_base_write: got %h expected 0", obs);
    end
    WB_EN = 1; ALURes = 32'h5; dest = 2;
    tick(); exp_cnt++;
    checks++;
    if (obs !== {1'b1, 5'd2, 32'h5, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL mid_after_release: got %h expected %h", obs, {1'b1, 5'd2, 32'h5, 1'b0, 4'd1});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    WB_EN = 1; MEM_R_EN = 0; dest = 1;
    for (int i = 1; i <= 17; i++) begin
      ALURes = 32'(i);
      tick();
      if (i == 16) begin
        checks++;
        if (wb_count !== 4'd0) begin
          errors++;
          $display("FAIL wrap_at_16: got %0d expected 0", wb_count);
        end
      end
    end
    checks++;
    if (wb_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_at_17: got %0d expected 1", wb_count);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_load();
    test_load_base();
    test_same_index();
    test_back_to_back();
    test_zero_and_base_only();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
